// File: rtl/sparc_ifu_lru_pkg.sv
// Shared constants and helpers for the IFU LRU thread scheduler.
// Holds the widest supported thread count, the reset recency order and the one-hot check.
package sparc_ifu_lru_pkg;

  localparam int NTHR_MAX = 8;

  // Position p starts out holding thread p, so thread 0 is MRU after reset.
  function automatic logic [NTHR_MAX-1:0] reset_order(int p);
    logic [NTHR_MAX-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return one << p;
  endfunction

  function automatic logic is_onehot(logic [NTHR_MAX-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NTHR_MAX; i++) cnt += int'(v[i]);
    return cnt == 1;
  endfunction

endpackage

// File: rtl/sparc_ifu_lru_arb_if.sv
// Fetch-select bus between the thread-ready logic and the LRU scheduler.
interface sparc_ifu_lru_arb_if #(parameter int NTHR = 4);

  logic [NTHR-1:0] recent_vec;
  logic            load_recent;
  logic [NTHR-1:0] req_vec;
  logic [NTHR-1:0] spec_vec;
  logic            use_spec;
  logic [NTHR-1:0] grant_vec;
  logic            starved;

  modport master (
    output recent_vec, load_recent, req_vec, spec_vec, use_spec,
    input  grant_vec, starved
  );

  modport slave (
    input  recent_vec, load_recent, req_vec, spec_vec, use_spec,
    output grant_vec, starved
  );

endinterface

// File: rtl/dff_s.sv
// Standard scan flop bank: scan enable selects the scan input over functional data.
module dff_s #(
  parameter int SIZE = 1
) (
  input  logic [SIZE-1:0] din,
  input  logic            clk,
  output logic [SIZE-1:0] q,
  input  logic            se,
  input  logic [SIZE-1:0] si
);

  always_ff @(posedge clk) begin
    q <= se ? si : din;
  end

endmodule

// File: rtl/sparc_ifu_lru_age.sv
// Per-thread saturating starvation counter for the aging build of the LRU scheduler.
module sparc_ifu_lru_age #(
  parameter int AGE_W   = 4,
  parameter int AGE_MAX = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic in_t,
  input  logic granted,
  output logic at_max
);

  localparam logic [AGE_W-1:0] AGE_SAT = '1;

  logic [AGE_W-1:0] age;

  // Waiting only accumulates while the thread keeps asking and keeps losing.
  always_ff @(posedge clk) begin
    if (reset || !in_t || granted) begin
      age <= '0;
    end else if (age != AGE_SAT) begin
      age <= age + AGE_W'(1);
    end
  end

  assign at_max = int'(age) >= AGE_MAX;

endmodule

// File: rtl/sparc_ifu_lru_arb.sv
// Parametrised LRU fetch-thread scheduler with a registered recency order.
// Define SPARC_IFU_LRU_AGE_EN to add starvation aging that can override the LRU pick.
module sparc_ifu_lru_arb
  import sparc_ifu_lru_pkg::*;
#(
  parameter int NTHR    = 4,
  parameter int AGE_W   = 4,
  parameter int AGE_MAX = 12
) (
  input logic                clk,
  input logic                reset,
  sparc_ifu_lru_arb_if.slave bus
);

  localparam bit CFG_OK = (NTHR >= 2) && (NTHR <= NTHR_MAX) && (AGE_W >= 1) &&
                          (AGE_MAX <= (1 << AGE_W) - 1);

  logic [NTHR-1:0] order     [NTHR];
  logic [NTHR-1:0] order_nxt [NTHR];
  logic [NTHR-1:0] tier;
  logic [NTHR-1:0] lru_pick;
  logic [NTHR-1:0] grant;
  logic            upd;

  assign upd = bus.load_recent && is_onehot(NTHR_MAX'(bus.recent_vec));

  for (genvar p = 0; p < NTHR; p++) begin : g_ord
    localparam logic [NTHR_MAX-1:0] RST_ORD = reset_order(p);
    dff_s #(.SIZE(NTHR)) u_ord (
      .din (reset ? RST_ORD[NTHR-1:0] : order_nxt[p]),
      .clk (clk),
      .q   (order[p]),
      .se  (1'b0),
      .si  ('0)
    );
  end

  // Positions at or below the recent thread's slot shift down; the recent thread becomes MRU.
  always_comb begin
    logic [NTHR-1:0] hit;
    logic [NTHR-1:0] at_or_above;
    logic            acc;
    acc         = 1'b0;
    hit         = '0;
    at_or_above = '0;
    for (int p = 0; p < NTHR; p++) order_nxt[p] = order[p];
    for (int p = NTHR - 1; p >= 0; p--) begin
      hit[p]         = |(order[p] & bus.recent_vec);
      acc            = acc | hit[p];
      at_or_above[p] = acc;
    end
    if (upd) begin
      order_nxt[0] = bus.recent_vec;
      for (int p = 1; p < NTHR; p++) begin
        if (at_or_above[p]) order_nxt[p] = order[p-1];
      end
    end
  end

  // Later positions overwrite earlier ones, so the deepest requester wins; MRU if none.
  always_comb begin
    tier     = bus.use_spec ? bus.spec_vec : bus.req_vec;
    lru_pick = order[0];
    for (int p = 0; p < NTHR; p++) begin
      if (|(order[p] & tier)) lru_pick = order[p];
    end
  end

`ifdef SPARC_IFU_LRU_AGE_EN
  logic [NTHR-1:0] at_max;
  logic [NTHR-1:0] starve_vec;
  logic [NTHR-1:0] starve_pick;

  assign starve_vec  = at_max & tier;
  assign starve_pick = starve_vec & (~starve_vec + NTHR'(1));
  assign grant       = (|starve_vec) ? starve_pick : lru_pick;
  assign bus.starved = !reset && (|starve_vec);

  for (genvar t = 0; t < NTHR; t++) begin : g_age
    sparc_ifu_lru_age #(.AGE_W(AGE_W), .AGE_MAX(AGE_MAX)) u_age (
      .clk     (clk),
      .reset   (reset),
      .in_t    (tier[t]),
      .granted (grant[t]),
      .at_max  (at_max[t])
    );
  end
`else
  assign grant       = lru_pick;
  assign bus.starved = 1'b0;
`endif

  assign bus.grant_vec = reset ? '0 : grant;

  a_cfg_ok: assert property (@(posedge clk) CFG_OK);

  a_recent_onehot: assert property (@(posedge clk) disable iff (reset)
    bus.load_recent |-> (bus.recent_vec == '0 || is_onehot(NTHR_MAX'(bus.recent_vec))));

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    is_onehot(NTHR_MAX'(bus.grant_vec)));

endmodule

// File: tb/tb_sparc_ifu_lru_arb.sv
// Scoreboard bench for sparc_ifu_lru_arb: 4-thread and 8-thread instances, directed vectors.
module tb_sparc_ifu_lru_arb;

  typedef struct {
    int         cyc;
    int         dut;
    logic [7:0] grant;
    logic       starved;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sparc_ifu_lru_arb_if #(.NTHR(4)) bus4 ();
  sparc_ifu_lru_arb_if #(.NTHR(8)) bus8 ();

  sparc_ifu_lru_arb #(.NTHR(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  sparc_ifu_lru_arb #(.NTHR(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  task automatic check_output(input int dut, input logic [7:0] grant, input logic starved,
                              input string name);
    exp_t e;
    e.cyc     = cyc;
    e.dut     = dut;
    e.grant   = grant;
    e.starved = starved;
    e.name    = name;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input int dut, input logic load, input logic [7:0] recent,
                                input logic [7:0] req, input logic [7:0] spec, input logic use_s);
    @(posedge clk);
    #1;
    reset = 1'b0;
    if (dut == 4) begin
      bus4.load_recent = load;
      bus4.recent_vec  = recent[3:0];
      bus4.req_vec     = req[3:0];
      bus4.spec_vec    = spec[3:0];
      bus4.use_spec    = use_s;
    end else begin
      bus8.load_recent = load;
      bus8.recent_vec  = recent;
      bus8.req_vec     = req;
      bus8.spec_vec    = spec;
      bus8.use_spec    = use_s;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_output(4, 8'h00, 1'b0, "reset4");
    check_output(8, 8'h00, 1'b0, "reset8");
  endtask

  // Monitor: compare every queued expectation whose cycle has come up.
  initial begin
    exp_t       e;
    logic [7:0] act;
    logic       act_s;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.dut == 4) begin
          act   = {4'b0000, bus4.grant_vec};
          act_s = bus4.starved;
        end else begin
          act   = bus8.grant_vec;
          act_s = bus8.starved;
        end
        checks++;
        if (e.cyc != cyc || act !== e.grant || act_s !== e.starved) begin
          errors++;
          $display("[TB] FAIL %s: cycle %0d got grant=%h starved=%b, expected grant=%h starved=%b (cycle %0d)",
                   e.name, cyc, act, act_s, e.grant, e.starved, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus4.load_recent = 1'b0;
    bus4.recent_vec  = '0;
    bus4.req_vec     = 4'b1111;
    bus4.spec_vec    = '0;
    bus4.use_spec    = 1'b0;
    bus8.load_recent = 1'b0;
    bus8.recent_vec  = '0;
    bus8.req_vec     = '0;
    bus8.spec_vec    = '0;
    bus8.use_spec    = 1'b0;

    repeat (2) begin
      @(posedge clk);
      #1;
      check_output(4, 8'h00, 1'b0, "reset_grant");
    end

    apply_stimulus(4, 1'b0, 8'h0, 8'b1111, 8'h0, 1'b0); check_output(4, 8'b1000, 1'b0, "lru_after_reset");
    apply_stimulus(4, 1'b1, 8'b1000, 8'b1111, 8'h0, 1'b0); check_output(4, 8'b1000, 1'b0, "pre_update_grant");
    apply_stimulus(4, 1'b0, 8'h0, 8'b1111, 8'h0, 1'b0); check_output(4, 8'b0100, 1'b0, "after_load_t3");

    pulse_reset();
    apply_stimulus(4, 1'b0, 8'h0, 8'b0000, 8'b0011, 1'b1); check_output(4, 8'b0010, 1'b0, "spec_tier");
    apply_stimulus(4, 1'b0, 8'h0, 8'b0000, 8'b0011, 1'b0); check_output(4, 8'b0001, 1'b0, "mru_fallback");
    apply_stimulus(4, 1'b1, 8'b0001, 8'b1111, 8'h0, 1'b0); check_output(4, 8'b1000, 1'b0, "load_mru");
    apply_stimulus(4, 1'b1, 8'b0000, 8'b1111, 8'h0, 1'b0); check_output(4, 8'b1000, 1'b0, "load_mru_hold");
    apply_stimulus(4, 1'b0, 8'h0, 8'b1111, 8'h0, 1'b0); check_output(4, 8'b1000, 1'b0, "load_zero_hold");
    apply_stimulus(4, 1'b1, 8'b0100, 8'b1111, 8'h0, 1'b0); check_output(4, 8'b1000, 1'b0, "load_t2");
    apply_stimulus(4, 1'b0, 8'h0, 8'b1111, 8'h0, 1'b0); check_output(4, 8'b1000, 1'b0, "after_t2_full");
    apply_stimulus(4, 1'b0, 8'h0, 8'b0111, 8'h0, 1'b0); check_output(4, 8'b0010, 1'b0, "after_t2_partial");
    apply_stimulus(4, 1'b1, 8'b0010, 8'b0111, 8'h0, 1'b0); check_output(4, 8'b0010, 1'b0, "load_t1");
    apply_stimulus(4, 1'b0, 8'h0, 8'b0111, 8'h0, 1'b0); check_output(4, 8'b0001, 1'b0, "after_t1");
    apply_stimulus(4, 1'b0, 8'h0, 8'b0000, 8'b0110, 1'b1); check_output(4, 8'b0100, 1'b0, "spec_after_t1");
    apply_stimulus(4, 1'b0, 8'h0, 8'b0110, 8'b0001, 1'b1); check_output(4, 8'b0001, 1'b0, "spec_select");
    apply_stimulus(4, 1'b0, 8'h0, 8'b0110, 8'b0001, 1'b0); check_output(4, 8'b0100, 1'b0, "req_select");
    apply_stimulus(4, 1'b0, 8'h0, 8'b0000, 8'b0000, 1'b0); check_output(4, 8'b0010, 1'b0, "idle_mru");

    pulse_reset();
    for (int t = 7; t >= 0; t--) begin
      apply_stimulus(8, 1'b1, 8'(1 << t), 8'hFF, 8'h00, 1'b0);
      check_output(8, 8'(1 << t), 1'b0, "n8_lru_step");
    end
    apply_stimulus(8, 1'b0, 8'h0, 8'hFF, 8'h00, 1'b0); check_output(8, 8'h80, 1'b0, "n8_reset_order");
    apply_stimulus(8, 1'b0, 8'h0, 8'h00, 8'h00, 1'b0); check_output(8, 8'h01, 1'b0, "n8_idle_mru");

`ifdef SPARC_IFU_LRU_AGE_EN
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(4, 1'b0, 8'h0, 8'b1001, 8'h0, 1'b0);
      check_output(4, 8'b1000, 1'b0, "age_wait");
    end
    apply_stimulus(4, 1'b0, 8'h0, 8'b1001, 8'h0, 1'b0); check_output(4, 8'b0001, 1'b1, "age_starved");
    apply_stimulus(4, 1'b0, 8'h0, 8'b1001, 8'h0, 1'b0); check_output(4, 8'b1000, 1'b0, "age_cleared");
`endif

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
